arm32_mem_responder: RTL

ARM32_MEM_RESPONDER -- requirements
Module: arm32_mem_responder

---
 rtl/arm32_pkg.sv | 22 ++
 rtl/arm32_sram.sv | 37 +++
 rtl/arm32_mem_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/arm32_pkg.sv
// Shared definitions for the ARM32 core and its memory-side blocks.
package arm32_pkg;

  localparam int ARCH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Expand 4 byte enables into a 32-bit bit-mask.
  function automatic logic [ARCH-1:0] be_mask(input logic [3:0] be);
    logic [ARCH-1:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{be[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/arm32_sram.sv
// DEPTH x 32 single-port synchronous SRAM with byte-write enables.
// No reset on the array: contents survive reset. Program/data images are
// preloaded into the r_mem array of this instance.
module arm32_sram
  import arm32_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_en,
  input  logic            i_we,
  input  logic [AW-1:0]   i_addr,
  input  logic [ARCH-1:0] i_wdata,
  input  logic [3:0]      i_be,
  output logic [ARCH-1:0] o_rdata
);

  logic [ARCH-1:0] r_mem [DEPTH];
  logic [ARCH-1:0] r_rdata;
  logic [ARCH-1:0] w_mask;

  assign w_mask  = be_mask(i_be);
  assign o_rdata = r_rdata;

  // One access per enabled cycle; read data only updates on a read, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= (r_mem[i_addr] & ~w_mask) | (i_wdata & w_mask);
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/arm32_mem_responder.sv
// Load/store responder for the ARM32 core: one request at a time, fixed
// wait states, then a response held until the CPU accepts it.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request captured, counting down wait states
// RESP  | response presented, held until rsp_ready
//
// The SRAM access (read sample or store commit) happens on the edge that
// enters RESP, so the address/controls fed to the SRAM come straight from
// the request bus when entering RESP directly from IDLE (zero wait states).
module arm32_mem_responder
  import arm32_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [ARCH-1:0] req_addr,
  input  logic [ARCH-1:0] req_wdata,
  input  logic [3:0]      req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ARCH-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [ARCH-1:0] r_addr;
  logic [ARCH-1:0] r_wdata;
  logic [3:0]      r_be;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic            r_rsp_err;
  logic            r_rd_ok;

  logic            w_idle;
  logic            w_accept;
  logic            w_we;
  logic [ARCH-1:0] w_addr;
  logic [ARCH-1:0] w_wdata;
  logic [3:0]      w_be;
  logic            w_err;
  logic            w_enter;
  logic [ARCH-1:0] w_sram_rdata;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = req_valid & r_req_ready;

  assign w_we    = w_idle ? req_we    : r_we;
  assign w_addr  = w_idle ? req_addr  : r_addr;
  assign w_wdata = w_idle ? req_wdata : r_wdata;
  assign w_be    = w_idle ? req_be    : r_be;

  assign w_err = (w_addr[1:0] != 2'b00) || ({2'b00, w_addr[ARCH-1:2]} >= 32'(DEPTH));

  assign w_enter = (w_accept && (WAIT_CYCLES == 0)) ||
                   ((r_state == WAIT) && (r_cnt == 4'd0));

  arm32_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_enter & ~w_err),
    .i_we    (w_we),
    .i_addr  (w_addr[AW+1:2]),
    .i_wdata (w_wdata),
    .i_be    (w_be),
    .o_rdata (w_sram_rdata)
  );

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rd_ok ? w_sram_rdata : '0;

  // Request/response sequencing with registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= 4'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rd_ok     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_be        <= req_be;
            r_req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_err;
              r_rd_ok     <= ~w_err & ~w_we;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rd_ok     <= ~w_err & ~w_we;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_ok     <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
